// File: rtl/mutation_pipe.sv
// mutation_pipe: per-bit random mutation stage for N_CHILD genomes of
// GENE_W bits. Each accepted transaction flips bit f when mut_en is set and
// its RATE_W-bit draw from a bank of 32-bit Galois LFSRs is below mut_rate.
// The result is registered with a one-cycle latency behind a valid/ready
// handshake. Per-result and saturating cumulative flip counts are kept.
//
// Ports:
//   clk           clock
//   reset         synchronous active-low reset
//   in_valid      input transaction valid
//   in_ready      block can accept input
//   in_children   packed children, child c at [c*GENE_W +: GENE_W]
//   mut_rate      flip threshold, sampled on accept
//   mut_en        0 = pass-through, sampled on accept
//   out_valid     result valid
//   out_ready     downstream accepts result
//   out_children  mutated children, same packing
//   flip_count    number of bits flipped in the presented result
//   total_flips   saturating cumulative flips since reset/clear
//   stats_clr     synchronous clear of total_flips
module mutation_pipe #(
  parameter int          GENE_W  = 8,
  parameter int          N_CHILD = 2,
  parameter int          RATE_W  = 8,
  parameter logic [31:0] SEED    = 32'hA1EF_CDE5,
  parameter int          CNT_W   = 32,
  localparam int         NB      = N_CHILD * GENE_W,
  localparam int         FC_W    = $clog2(NB + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NB-1:0]     in_children,
  input  logic [RATE_W-1:0] mut_rate,
  input  logic              mut_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NB-1:0]     out_children,
  output logic [FC_W-1:0]   flip_count,
  output logic [CNT_W-1:0]  total_flips,
  input  logic              stats_clr
);

  localparam int          NL        = (NB * RATE_W + 31) / 32;
  localparam int          SUM_W     = ((CNT_W > FC_W) ? CNT_W : FC_W) + 1;
  localparam logic [31:0] POLY      = 32'h8020_0003;
  localparam logic [31:0] SEED_STEP = 32'h1248_8421;
  localparam logic [SUM_W-1:0] TOT_MAX = SUM_W'({CNT_W{1'b1}});

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  function automatic logic [31:0] lfsr_seed(input int k);
    logic [31:0] s;
    s = SEED + SEED_STEP * 32'(k);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  logic [NL*32-1:0] lfsr;
  logic [NL*32-1:0] lfsr_nxt;
  logic [NB-1:0]    mask;
  logic [FC_W-1:0]  fc_nxt;
  logic [SUM_W-1:0] sum;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Draws come from the pre-advance LFSR states, LFSR 0 in the LSBs.
  always_comb begin
    mask   = '0;
    fc_nxt = '0;
    for (int f = 0; f < NB; f++) begin
      mask[f] = mut_en && (lfsr[f*RATE_W +: RATE_W] < mut_rate);
      fc_nxt  = fc_nxt + FC_W'(mask[f]);
    end
  end

  always_comb begin
    lfsr_nxt = lfsr;
    for (int k = 0; k < NL; k++) begin
      lfsr_nxt[k*32 +: 32] = {1'b0, lfsr[k*32+1 +: 31]} ^ (lfsr[k*32] ? POLY : 32'h0);
    end
  end

  // One spare bit so the saturation compare sees the carry.
  assign sum = SUM_W'(total_flips) + SUM_W'(fc_nxt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_children <= '0;
      flip_count   <= '0;
      total_flips  <= '0;
      for (int k = 0; k < NL; k++) begin
        lfsr[k*32 +: 32] <= lfsr_seed(k);
      end
    end else begin
      if (accept) begin
        out_valid    <= 1'b1;
        out_children <= in_children ^ mask;
        flip_count   <= fc_nxt;
        lfsr         <= lfsr_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (stats_clr) begin
        total_flips <= '0;
      end else if (accept) begin
        total_flips <= (sum > TOT_MAX) ? TOT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mutation_pipe.sv
module tb_mutation_pipe;

  localparam int GW   = 8;
  localparam int NC   = 2;
  localparam int RW   = 8;
  localparam int NB   = NC * GW;
  localparam int FCW  = $clog2(NB + 1);
  localparam int NL   = (NB * RW + 31) / 32;
  localparam logic [31:0] SEED = 32'hA1EF_CDE5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [NB-1:0] in_children = '0;
  logic [RW-1:0] mut_rate = '0;
  logic mut_en = 1'b0;
  logic out_ready = 1'b0;
  logic stats_clr = 1'b0;

  logic in_ready, out_valid;
  logic [NB-1:0] out_children;
  logic [FCW-1:0] flip_count;
  logic [31:0] total_flips;

  logic in_ready_s, out_valid_s;
  logic [NB-1:0] out_children_s;
  logic [FCW-1:0] flip_count_s;
  logic [3:0] total_sat;

  mutation_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_children(in_children), .mut_rate(mut_rate), .mut_en(mut_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_children(out_children),
    .flip_count(flip_count), .total_flips(total_flips), .stats_clr(stats_clr)
  );

  mutation_pipe #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_children(in_children), .mut_rate(mut_rate), .mut_en(mut_en),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_children(out_children_s),
    .flip_count(flip_count_s), .total_flips(total_sat), .stats_clr(stats_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] kids;
    int            fc;
    longint        tot;
    int            tot_sat;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  longint acc = 0;

  logic [31:0] m_lfsr [NL];
  longint      m_tot;
  int          m_sat;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NL; k++) begin
      m_lfsr[k] = SEED + 32'(k) * 32'h1248_8421;
      if (m_lfsr[k] == 32'h0) m_lfsr[k] = 32'h1;
    end
    m_tot = 0;
    m_sat = 0;
  endfunction

  // Reference: draw f is built bit by bit from the concatenated LFSR words.
  function automatic void model_accept(logic [NB-1:0] kids, int rate, bit en, bit clr);
    exp_t e;
    int fc = 0;
    logic [NB-1:0] res = kids;
    for (int f = 0; f < NB; f++) begin
      int draw = 0;
      for (int j = 0; j < RW; j++) begin
        int i = f * RW + j;
        draw += int'(m_lfsr[i / 32][i % 32]) << j;
      end
      if (en && draw < rate) begin
        res[f] = ~res[f];
        fc++;
      end
    end
    for (int k = 0; k < NL; k++) begin
      m_lfsr[k] = m_lfsr[k][0] ? ((m_lfsr[k] >> 1) ^ 32'h8020_0003) : (m_lfsr[k] >> 1);
    end
    if (clr) begin
      m_tot = 0;
      m_sat = 0;
    end else begin
      m_tot = (m_tot + fc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tot + fc;
      m_sat = (m_sat + fc > 15) ? 15 : m_sat + fc;
    end
    e.kids = res;
    e.fc = fc;
    e.tot = m_tot;
    e.tot_sat = m_sat;
    q.push_back(e);
  endfunction

  task automatic cyc(bit v, logic [NB-1:0] kids, int rate, bit en, bit ordy, bit clr);
    @(negedge clk);
    in_valid = v;
    in_children = kids;
    mut_rate = RW'(rate);
    mut_en = en;
    out_ready = ordy;
    stats_clr = clr;
    #1;
    if (reset && in_valid && in_ready) model_accept(kids, rate, en, clr);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    q.delete();
    model_reset();
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_total", total_flips, 0);
      chk("rst_total_sat", total_sat, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, '0, 0, 0, 1, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      acc = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected no result", out_children);
      end else begin
        chk("out_children", out_children, q[0].kids);
        chk("flip_count", flip_count, q[0].fc);
        chk("total_flips", total_flips, q[0].tot);
        chk("sat_out_valid", out_valid_s, 1);
        chk("sat_children", out_children_s, q[0].kids);
        chk("sat_flip_count", flip_count_s, q[0].fc);
        chk("total_sat", total_sat, q[0].tot_sat);
        if (out_ready) begin
          void'(q.pop_front());
          acc += flip_count;
        end
      end
    end
  end

  longint base;
  longint diff;
  int     waited;

  initial begin
    model_reset();
    do_reset(3);

    cyc(1, {8'hC3, 8'h5A}, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("first_children", out_children, 16'hC35A);
    chk("first_flip_count", flip_count, 0);

    idle(3);
    base = total_flips;
    repeat (1000) cyc(1, NB'($urandom), 12, 1, 1, 0);
    idle(3);
    @(negedge clk);
    #3;
    chk("total_eq_sum", total_flips, acc);
    diff = total_flips - base;
    checks++;
    if (diff < 590 || diff > 910) begin
      errors++;
      $display("FAIL flip_rate: got %0d flips in 16000 bits expected 590..910", diff);
    end

    cyc(1, NB'($urandom), 12, 1, 1, 0);
    repeat (5) begin
      cyc(1, NB'($urandom), 12, 1, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_in_ready_sat", in_ready_s, 0);
    end
    repeat (10) cyc(1, NB'($urandom), 12, 1, 1, 0);

    repeat (20) cyc(1, NB'($urandom), 255, 0, 1, 0);
    repeat (10) cyc(1, NB'($urandom), 12, 1, 1, 0);

    repeat (5) cyc(1, NB'($urandom), 255, 1, 1, 0);
    idle(2);
    @(negedge clk);
    #3;
    chk("sat_sticks", total_sat, 15);
    cyc(1, NB'($urandom), 255, 1, 1, 1);
    @(posedge clk);
    #1;
    chk("clr_total", total_flips, 0);
    chk("clr_total_sat", total_sat, 0);
    idle(2);

    cyc(1, NB'($urandom), 12, 1, 1, 0);
    cyc(0, '0, 12, 1, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    do_reset(1);
    cyc(1, NB'($urandom), 200, 1, 1, 0);
    idle(2);

    repeat (300) begin
      cyc($urandom_range(0, 1) == 1, NB'($urandom), int'($urandom_range(0, 255)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0);
    end

    waited = 0;
    while (q.size() != 0 && waited < 50) begin
      idle(1);
      waited++;
    end
    @(negedge clk);
    #3;
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
